// File: rtl/exp6mod47_ctrl_pkg.sv
// Shared constants and FSM encoding for the mod-47 exponentiation engine.
package exp6mod47_ctrl_pkg;

  localparam int OP_W = 6;
  localparam logic [OP_W:1] MOD47 = 6'd47;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SQ   = 2'd1,
    ST_MUL  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/exp6mod47_ctrl_if.sv
// Host-side request/response bundle for exp6mod47_ctrl, plus FSM state for observation.
interface exp6mod47_ctrl_if import exp6mod47_ctrl_pkg::*; #(parameter int EXP_W = 6) ();

  // start is a request sampled only while idle; done/err are single-cycle pulses,
  // busy is high from the accepting edge until the cycle after done.
  logic            start;
  logic [OP_W:1]   base;
  logic [EXP_W:1]  exp;
  logic            busy;
  logic            done;
  logic            err;
  logic [OP_W:1]   result;
  state_t          state;

  modport master (output start, base, exp, input busy, done, err, result, state);
  modport slave  (input start, base, exp, output busy, done, err, result, state);

endinterface

// File: rtl/exp6mod47_ctrl_mul.sv
// Combinational 6-bit modular multiplier (mul6ABmod47): y = a*b mod 47.
module exp6mod47_ctrl_mul
  import exp6mod47_ctrl_pkg::*;
(
  input  logic [OP_W:1] a,
  input  logic [OP_W:1] b,
  output logic [OP_W:1] y
);

  logic [2*OP_W-1:0] prod;

  always_comb begin
    prod = {{OP_W{1'b0}}, a} * {{OP_W{1'b0}}, b};
    y    = OP_W'(prod % {{OP_W{1'b0}}, MOD47});
  end

endmodule

// File: rtl/exp6mod47_ctrl.sv
// Left-to-right square-and-multiply engine computing base^exp mod 47,
// one modular product per cycle through a single shared multiplier.
module exp6mod47_ctrl
  import exp6mod47_ctrl_pkg::*;
#(
  parameter int EXP_W = 6
) (
  input logic               clk,
  input logic               rst,
  exp6mod47_ctrl_if.slave   bus
);

  localparam int CNT_W = $clog2(EXP_W + 1);

  state_t           state, state_n;
  logic [OP_W:1]    base_r, acc, result_r, mul_b, prod;
  logic [EXP_W:1]   exp_r;
  logic [CNT_W-1:0] cnt;
  logic             err_r, accept, last;

  exp6mod47_ctrl_mul u_mul (
    .a (acc),
    .b (mul_b),
    .y (prod)
  );

  always_comb begin
    state_n = ST_IDLE;
    mul_b   = acc;
    accept  = 1'b0;
    last    = (cnt == CNT_W'(1));
    case (state)
      ST_IDLE: begin
        accept  = bus.start && (bus.base < MOD47);
        state_n = accept ? ST_SQ : ST_IDLE;
      end
      ST_SQ: begin
        if (exp_r[cnt])  state_n = ST_MUL;
        else if (last)   state_n = ST_DONE;
        else             state_n = ST_SQ;
      end
      ST_MUL: begin
        mul_b   = base_r;
        state_n = last ? ST_DONE : ST_SQ;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // cnt only moves after the current exponent bit is fully consumed, so a set
  // bit costs one SQ and one MUL cycle while cnt is held.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      base_r   <= '0;
      exp_r    <= '0;
      acc      <= '0;
      cnt      <= '0;
      result_r <= '0;
      err_r    <= 1'b0;
    end else begin
      state <= state_n;
      err_r <= (state == ST_IDLE) && bus.start && !(bus.base < MOD47);
      case (state)
        ST_IDLE: begin
          if (accept) begin
            base_r <= bus.base;
            exp_r  <= bus.exp;
            acc    <= OP_W'(1);
            cnt    <= CNT_W'(EXP_W);
          end
        end
        ST_SQ: begin
          acc <= prod;
          if (!exp_r[cnt]) begin
            if (last) result_r <= prod;
            else      cnt      <= cnt - CNT_W'(1);
          end
        end
        ST_MUL: begin
          acc <= prod;
          if (last) result_r <= prod;
          else      cnt      <= cnt - CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign bus.busy   = (state != ST_IDLE);
  assign bus.done   = (state == ST_DONE);
  assign bus.err    = err_r;
  assign bus.result = result_r;
  assign bus.state  = state;

endmodule
